// File: rtl/mul_div_unit_if.sv
// Request/result bundle for mul_div_unit; the master side issues operations, the slave side executes them.
// Handshake: a request (mult_ctrl or div_ctrl) is taken on the rising edge where busy is low; results on hi/lo are valid from the mult_end/div_end pulse until the next completion.
interface mul_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             mult_ctrl;
  logic             div_ctrl;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             mult_end;
  logic             div_end;
  logic             div_zero;
  logic             busy;
  logic [2:0]       state;

  modport master (
    output mult_ctrl, div_ctrl, signed_op, a, b,
    input  hi, lo, mult_end, div_end, div_zero, busy, state
  );

  modport slave (
    input  mult_ctrl, div_ctrl, signed_op, a, b,
    output hi, lo, mult_end, div_end, div_zero, busy, state
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider, one bit per cycle on operand magnitudes.
// Define DIV_ZERO_TRAP_EN to finish a divide by zero immediately with div_zero instead of running it.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input logic         clock,
  input logic         reset,
  mul_div_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);

  state_t             state, state_next;
  logic [WIDTH-1:0]   count;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   acc_hi, acc_lo;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               is_div, neg_res, neg_rem, zero_div;

  logic               start_mult, start_div;
  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_rem;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  // Multiply wins when both requests arrive together.
  assign start_mult = (state == IDLE) && bus.mult_ctrl;
  assign start_div  = (state == IDLE) && !bus.mult_ctrl && bus.div_ctrl;

  assign a_neg  = bus.signed_op & bus.a[WIDTH-1];
  assign b_neg  = bus.signed_op & bus.b[WIDTH-1];
  assign mag_a  = a_neg ? -bus.a : bus.a;
  assign mag_b  = b_neg ? -bus.b : bus.b;
  assign b_zero = (bus.b == '0);

  // acc_lo holds the multiplier bits (multiply) or the dividend/quotient bits (divide).
  assign mult_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : {(WIDTH+1){1'b0}});
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_rem   = div_shift[WIDTH-1:0] - op_b;
  assign q_bit     = (div_shift >= {1'b0, op_b});

  assign prod     = {acc_hi, acc_lo};
  assign prod_fix = neg_res ? -prod : prod;

  always_comb begin
    fix_hi = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo = prod_fix[WIDTH-1:0];
    if (is_div) begin
      fix_lo = neg_res ? -acc_lo : acc_lo;
      fix_hi = neg_rem ? -acc_hi : acc_hi;
      if (zero_div) fix_lo = '1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start_mult) state_next = MULT;
        else if (start_div) begin
`ifdef DIV_ZERO_TRAP_EN
          state_next = b_zero ? DONE : DIV;
`else
          state_next = DIV;
`endif
        end
      end
      MULT, DIV: if (count == LAST) state_next = FIX;
      FIX:       state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count    <= '0;
      op_b     <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      zero_div <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_mult || start_div) begin
            is_div   <= start_div;
            count    <= '0;
            acc_hi   <= '0;
            acc_lo   <= start_mult ? mag_b : mag_a;
            op_b     <= start_mult ? mag_a : mag_b;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            zero_div <= start_div && b_zero;
          end
        end
        MULT: begin
          acc_hi <= mult_sum[WIDTH:1];
          acc_lo <= {mult_sum[0], acc_lo[WIDTH-1:1]};
          count  <= count + 1'b1;
        end
        DIV: begin
          acc_hi <= q_bit ? div_rem : div_shift[WIDTH-1:0];
          acc_lo <= {acc_lo[WIDTH-2:0], q_bit};
          count  <= count + 1'b1;
        end
        FIX: begin
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy     = (state != IDLE);
    bus.mult_end = (state == DONE) && !is_div;
    bus.div_end  = (state == DONE) && is_div;
`ifdef DIV_ZERO_TRAP_EN
    bus.div_zero = (state == DONE) && is_div && zero_div;
`else
    bus.div_zero = 1'b0;
`endif
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.state = state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit at WIDTH=32: result values, completion latency, arbitration, reset abort.
module tb_mul_div_unit;
  localparam int WIDTH = 32;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mul_div_unit_if #(.WIDTH(WIDTH)) bus ();
  mul_div_unit #(.WIDTH(WIDTH)) dut (.clock(clock), .reset(reset), .bus(bus));

  int vectors = 0;
  int miscompares = 0;
  logic [WIDTH-1:0] exp_q[$];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request, then wait for its end pulse; lat counts edges from the accepting edge.
  task automatic run_op(input logic m, input logic d, input logic s,
                        input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        output int lat, output logic sm, output logic sd, output logic sz);
    @(negedge clock);
    bus.mult_ctrl = m; bus.div_ctrl = d; bus.signed_op = s; bus.a = av; bus.b = bv;
    @(posedge clock); #1;
    bus.mult_ctrl = 1'b0; bus.div_ctrl = 1'b0;
    lat = -1; sm = 1'b0; sd = 1'b0; sz = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      if (bus.mult_end || bus.div_end) begin
        lat = k; sm = bus.mult_end; sd = bus.div_end; sz = bus.div_zero;
        break;
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic settle();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mult_ctrl = 1'b1; bus.div_ctrl = 1'b1; bus.signed_op = 1'b0; bus.a = 32'd3; bus.b = 32'd3;
    repeat (3) @(posedge clock);
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
    vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
    vectors++; if ({bus.mult_end, bus.div_end, bus.div_zero} !== 3'b000) begin
      miscompares++; $display("FAIL reset_pulses: got %b expected 000", {bus.mult_end, bus.div_end, bus.div_zero});
    end
    vectors++; if (bus.state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
    bus.mult_ctrl = 1'b0; bus.div_ctrl = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    settle();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle: got busy %b expected 0", bus.busy); end
  endtask

  task automatic test_mult();
    logic [WIDTH-1:0] va[4], vb[4], eh[4], el[4];
    logic vs[4];
    logic [WIDTH-1:0] exp;
    int lat; logic sm, sd, sz;
    va = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFB};
    vb = '{32'd7,        32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFA};
    vs = '{1'b1,         1'b0,         1'b1,         1'b1};
    eh = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h40000000, 32'h00000000};
    el = '{32'hFFFFFFEB, 32'h00000001, 32'h00000000, 32'd30};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(eh[i]); exp_q.push_back(el[i]);
      run_op(1'b1, 1'b0, vs[i], va[i], vb[i], lat, sm, sd, sz);
      vectors++; if (lat !== 34) begin miscompares++; $display("FAIL mult_latency[%0d]: got %0d expected 34", i, lat); end
      vectors++; if ({sm, sd} !== 2'b10) begin miscompares++; $display("FAIL mult_pulse[%0d]: got %b expected 10", i, {sm, sd}); end
      exp = exp_q.pop_front();
      vectors++; if (bus.hi !== exp) begin miscompares++; $display("FAIL mult_hi[%0d]: got %h expected %h", i, bus.hi, exp); end
      exp = exp_q.pop_front();
      vectors++; if (bus.lo !== exp) begin miscompares++; $display("FAIL mult_lo[%0d]: got %h expected %h", i, bus.lo, exp); end
      settle();
    end
  endtask

  task automatic test_div();
    logic [WIDTH-1:0] va[6], vb[6], eh[6], el[6];
    logic vs[6];
    logic [WIDTH-1:0] exp;
    int lat; logic sm, sd, sz;
    va = '{32'hFFFFFFF9, 32'hFFFFFFFF, 32'd7,        32'h80000000, 32'h80000000, 32'hFFFFFFF9};
    vb = '{32'd2,        32'h10,       32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vs = '{1'b1,         1'b0,         1'b1,         1'b1,         1'b0,         1'b1};
    eh = '{32'hFFFFFFFF, 32'hF,        32'd1,        32'h0,        32'h80000000, 32'hFFFFFFFF};
    el = '{32'hFFFFFFFD, 32'h0FFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'h0,        32'd3};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(eh[i]); exp_q.push_back(el[i]);
      run_op(1'b0, 1'b1, vs[i], va[i], vb[i], lat, sm, sd, sz);
      vectors++; if (lat !== 34) begin miscompares++; $display("FAIL div_latency[%0d]: got %0d expected 34", i, lat); end
      vectors++; if ({sm, sd, sz} !== 3'b010) begin miscompares++; $display("FAIL div_pulse[%0d]: got %b expected 010", i, {sm, sd, sz}); end
      exp = exp_q.pop_front();
      vectors++; if (bus.hi !== exp) begin miscompares++; $display("FAIL div_hi[%0d]: got %h expected %h", i, bus.hi, exp); end
      exp = exp_q.pop_front();
      vectors++; if (bus.lo !== exp) begin miscompares++; $display("FAIL div_lo[%0d]: got %h expected %h", i, bus.lo, exp); end
      settle();
    end
  endtask

  task automatic test_div_zero();
    logic [WIDTH-1:0] va[2], eh[2], el[2];
    logic vs[2];
    logic [WIDTH-1:0] exp;
    int lat, exp_lat; logic sm, sd, sz, exp_sz;
    run_op(1'b1, 1'b0, 1'b0, 32'd3, 32'd4, lat, sm, sd, sz);
    vectors++; if (bus.lo !== 32'd12) begin miscompares++; $display("FAIL dz_prior_lo: got %h expected 0000000c", bus.lo); end
    settle();
    va = '{32'd5, 32'hFFFFFFFB};
    vs = '{1'b0, 1'b1};
`ifdef DIV_ZERO_TRAP_EN
    exp_lat = 1; exp_sz = 1'b1;
    eh = '{32'h0, 32'h0};
    el = '{32'd12, 32'd12};
`else
    exp_lat = 34; exp_sz = 1'b0;
    eh = '{32'd5, 32'hFFFFFFFB};
    el = '{32'hFFFFFFFF, 32'hFFFFFFFF};
`endif
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(eh[i]); exp_q.push_back(el[i]);
      run_op(1'b0, 1'b1, vs[i], va[i], 32'h0, lat, sm, sd, sz);
      vectors++; if (lat !== exp_lat) begin miscompares++; $display("FAIL dz_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); end
      vectors++; if ({sm, sd, sz} !== {2'b01, exp_sz}) begin
        miscompares++; $display("FAIL dz_pulse[%0d]: got %b expected %b", i, {sm, sd, sz}, {2'b01, exp_sz});
      end
      exp = exp_q.pop_front();
      vectors++; if (bus.hi !== exp) begin miscompares++; $display("FAIL dz_hi[%0d]: got %h expected %h", i, bus.hi, exp); end
      exp = exp_q.pop_front();
      vectors++; if (bus.lo !== exp) begin miscompares++; $display("FAIL dz_lo[%0d]: got %h expected %h", i, bus.lo, exp); end
      settle();
      vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL dz_idle[%0d]: got busy %b expected 0", i, bus.busy); end
    end
  endtask

  task automatic test_both_requests();
    int lat, ndiv;
    @(negedge clock);
    bus.mult_ctrl = 1'b1; bus.div_ctrl = 1'b1; bus.signed_op = 1'b0; bus.a = 32'd6; bus.b = 32'd7;
    @(posedge clock); #1;
    bus.mult_ctrl = 1'b0; bus.div_ctrl = 1'b0;
    lat = -1; ndiv = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == 10) begin bus.div_ctrl = 1'b1; bus.a = 32'd99; bus.b = 32'd1; end
      if (k == 11) bus.div_ctrl = 1'b0;
      if (bus.mult_end && lat < 0) lat = k;
      if (bus.div_end) ndiv++;
      @(posedge clock); #1;
    end
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL both_mult_latency: got %0d expected 34", lat); end
    vectors++; if (ndiv !== 0) begin miscompares++; $display("FAIL both_div_end: got %0d pulses expected 0", ndiv); end
    vectors++; if (bus.lo !== 32'd42) begin miscompares++; $display("FAIL both_lo: got %h expected 0000002a", bus.lo); end
    vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL both_hi: got %h expected 0", bus.hi); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL both_idle: got busy %b expected 0", bus.busy); end
  endtask

  task automatic test_reset_abort();
    int lat, nend;
    @(negedge clock);
    bus.mult_ctrl = 1'b1; bus.div_ctrl = 1'b0; bus.signed_op = 1'b0; bus.a = 32'd3; bus.b = 32'd5;
    @(posedge clock); #1;
    bus.mult_ctrl = 1'b0;
    nend = 0;
    for (int k = 1; k <= 9; k++) begin
      if (bus.mult_end) nend++;
      @(posedge clock); #1;
    end
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL abort_busy_before: got %b expected 1", bus.busy); end
    reset = 1'b1;
    bus.mult_ctrl = 1'b1; bus.a = 32'd9; bus.b = 32'd9;
    @(posedge clock); #1;
    reset = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b expected 0", bus.busy); end
    vectors++; if ({bus.hi, bus.lo} !== 64'h0) begin miscompares++; $display("FAIL abort_hilo: got %h expected 0", {bus.hi, bus.lo}); end
    vectors++; if (bus.state !== 3'd0) begin miscompares++; $display("FAIL abort_state: got %0d expected 0", bus.state); end
    @(posedge clock); #1;
    bus.mult_ctrl = 1'b0;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL abort_reaccept: got busy %b expected 1", bus.busy); end
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      if (bus.mult_end) begin
        if (lat < 0) lat = k;
        else nend++;
      end
      @(posedge clock); #1;
    end
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL abort_next_latency: got %0d expected 34", lat); end
    vectors++; if (nend !== 0) begin miscompares++; $display("FAIL abort_stray_end: got %0d expected 0", nend); end
    vectors++; if (bus.lo !== 32'd81) begin miscompares++; $display("FAIL abort_next_lo: got %h expected 00000051", bus.lo); end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clock);
    bus.mult_ctrl = 1'b1; bus.div_ctrl = 1'b0; bus.signed_op = 1'b0; bus.a = 32'd2; bus.b = 32'd3;
    @(posedge clock); #1;
    bus.a = 32'd100; bus.b = 32'd100;
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (bus.mult_end) begin lat = k; break; end
      @(posedge clock); #1;
    end
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected 34", lat); end
    vectors++; if (bus.lo !== 32'd6) begin miscompares++; $display("FAIL b2b_first_lo: got %h expected 00000006", bus.lo); end
    @(posedge clock); #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL b2b_gap: got busy %b expected 0", bus.busy); end
    @(posedge clock); #1;
    bus.mult_ctrl = 1'b0;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_second_accept: got busy %b expected 1", bus.busy); end
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      if (bus.mult_end) begin lat = k; break; end
      @(posedge clock); #1;
    end
    vectors++; if (lat !== 34) begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected 34", lat); end
    vectors++; if (bus.lo !== 32'd10000) begin miscompares++; $display("FAIL b2b_second_lo: got %h expected 00002710", bus.lo); end
    settle();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_both_requests();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
